// File: rtl/rom_fetch_unit_pkg.sv
// Shared types for the ROM fetch unit: FSM states, FIFO depth, buffered entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// WORD_SIZE / ADDR_DEPTH fix the widths of the ROM data and word-address buses
// for every file that imports this package.
package fetch_pkg;

   localparam int WORD_SIZE        = 32;
   localparam int ADDR_DEPTH       = 10;
   localparam int FETCH_FIFO_DEPTH = 2;

   typedef logic [WORD_SIZE-1:0]  word_t;
   typedef logic [ADDR_DEPTH-1:0] addr_t;

   typedef enum logic {
      RESET_HOLD = 1'b0,
      RUN        = 1'b1
   } fetch_state_t;

   typedef struct packed {
      addr_t addr;
      word_t data;
   } fetch_entry_t;

   // Sequential word address; wraps from all-ones back to zero.
   function automatic addr_t next_addr(input addr_t a);
      return a + addr_t'(1);
   endfunction

endpackage

// File: rtl/rom_fetch_unit_if.sv
// Bus bundle between the fetch unit, the synchronous ROM and the core fetch stage.
// Latency: n/a (wires only).
// Backpressure: instr_vld/instr_rdy stream toward the core; the ROM port has none.
// master: fetch unit side (drives ROM request and instruction stream).
// slave : environment side (ROM read data, redirect, consumer ready).
interface rom_fetch_unit_if;
   import fetch_pkg::*;

   logic  rom_en;
   addr_t rom_addr;
   word_t rom_dat;
   logic  redirect_vld;
   addr_t redirect_addr;
   logic  instr_vld;
   logic  instr_rdy;
   word_t instr_dat;
   addr_t instr_addr;

   modport master (
      output rom_en, rom_addr, instr_vld, instr_dat, instr_addr,
      input  rom_dat, redirect_vld, redirect_addr, instr_rdy
   );

   modport slave (
      input  rom_en, rom_addr, instr_vld, instr_dat, instr_addr,
      output rom_dat, redirect_vld, redirect_addr, instr_rdy
   );

endinterface

// File: rtl/rom_fetch_unit_fifo.sv
// Two-entry FIFO of fetched {addr, data} words with synchronous clear.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: none internally; the caller must never push when full or pop when empty.
// Ports: clk, rst_n (async active-low); push_i/push_dat_i, pop_i, clear_i; count_o, head_o.
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  fetch_entry_t push_dat_i,
   input  logic         pop_i,
   input  logic         clear_i,
   output logic [1:0]   count_o,
   output fetch_entry_t head_o
);

   localparam int PTR_W = $clog2(FETCH_FIFO_DEPTH);
   localparam int CNT_W = $clog2(FETCH_FIFO_DEPTH + 1);

   fetch_entry_t     mem_q [FETCH_FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FETCH_FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rom_fetch_unit.sv
// Sequential ROM fetch initiator feeding the core through a valid/ready stream.
// Latency: request -> word at stream head 2 cycles; redirect in cycle c -> target valid in c+3.
// Backpressure: issues only while buffered + in-flight words (after this cycle's pop) stay below 2.
// Ports: clk, rst_n (async active-low); bus (master): ROM request/data, redirect, instruction stream.
module rom_fetch_unit
   import fetch_pkg::*;
#(
   parameter addr_t RESET_ADDR = '0
)(
   input logic              clk,
   input logic              rst_n,
   rom_fetch_unit_if.master bus
);

   fetch_state_t state_q, state_d;
   addr_t        pc_q, pc_d;
   logic         inflight_q, inflight_d;
   addr_t        inflight_addr_q, inflight_addr_d;

   logic [1:0]   fifo_count;
   fetch_entry_t fifo_head;
   fetch_entry_t push_entry;
   logic         instr_vld;
   logic         pop;
   logic         push;
   logic         issue;
   logic [2:0]   occupancy;

   assign instr_vld = (fifo_count != 2'd0);
   assign pop       = instr_vld & bus.instr_rdy;

   // Slots committed after this cycle's pop; a new request needs a free slot
   // for when its data lands next cycle, so the FIFO can never overflow.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = (state_q == RUN) && !bus.redirect_vld && (occupancy < 3'd2);

   // A redirect discards the response currently returning from the ROM.
   assign push       = inflight_q && !bus.redirect_vld;
   assign push_entry = '{addr: inflight_addr_q, data: bus.rom_dat};

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      inflight_d      = issue;
      inflight_addr_d = inflight_addr_q;
      case (state_q)
         RESET_HOLD: begin
            state_d = RUN;
            pc_d    = RESET_ADDR;
         end
         RUN: begin
            if (issue) begin
               pc_d            = next_addr(pc_q);
               inflight_addr_d = pc_q;
            end
         end
      endcase
      // Redirect overrides everything; back-to-back redirects leave the last target.
      if (bus.redirect_vld) pc_d = bus.redirect_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= RESET_HOLD;
         pc_q            <= RESET_ADDR;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
      end
   end

   fetch_fifo u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push),
      .push_dat_i (push_entry),
      .pop_i      (pop),
      .clear_i    (bus.redirect_vld),
      .count_o    (fifo_count),
      .head_o     (fifo_head)
   );

   assign bus.rom_en     = issue;
   assign bus.rom_addr   = pc_q;
   assign bus.instr_vld  = instr_vld;
   assign bus.instr_dat  = fifo_head.data;
   assign bus.instr_addr = fifo_head.addr;

endmodule

// File: doc/rom_fetch_unit.md
# rom_fetch_unit

Sequential fetch initiator that drives the synchronous instruction ROM's ENABLE/ADDR port and presents fetched words to the core through a valid/ready stream. It sits between the core's fetch stage and the ROM. It tracks the ROM's one-cycle registered read latency, buffers up to two words, and supports a redirect (branch/jump) that flushes buffered and in-flight words.

## Interface
- WORD_SIZE, 32, instruction word width; must match the ROM.
- ADDR_DEPTH, 10, ROM address width in bits; addresses are word indices.
- RESET_ADDR, 0, first fetch address after reset.
- CLK  input  1  clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- ROM_ENABLE  output  1  read request to the ROM; sampled by the ROM on CLK rising edge.
- ROM_ADDR  output  ADDR_DEPTH  word address of the request.
- ROM_DATA  input  WORD_SIZE  ROM read data, valid the cycle after the request edge.
- REDIRECT  input  1  flush and restart fetch at REDIRECT_ADDR.
- REDIRECT_ADDR  input  ADDR_DEPTH  new fetch address.
- INSTR_VALID  output  1  INSTR_DATA/INSTR_ADDR hold a fetched word.
- INSTR_READY  input  1  consumer accepts the word this cycle.
- INSTR_DATA  output  WORD_SIZE  fetched word (FIFO head).
- INSTR_ADDR  output  ADDR_DEPTH  address of INSTR_DATA.

## Operation
- State: PC (next fetch address), INFLIGHT flag with its address, 2-entry FIFO of {addr, data}, FSM {RESET_HOLD, RUN}.
- RESET_HOLD is entered on reset and lasts one cycle with no issue. It then moves to RUN with PC=RESET_ADDR.
- Issue in RUN when the combinational condition count + INFLIGHT − pop < 2 holds and REDIRECT=0.
  - pop = INSTR_VALID & INSTR_READY.
  - On issue: ROM_ENABLE=1 and ROM_ADDR=PC. At the edge, INFLIGHT←1 and PC←PC+1 modulo 2^ADDR_DEPTH, wrapping from all-ones to 0.
- When not issuing, ROM_ENABLE=0 and ROM_ADDR=PC.
- Capture: if INFLIGHT=1 at an edge, push {inflight addr, ROM_DATA} into the FIFO. ROM_DATA is ignored whenever INFLIGHT=0, because the ROM returns 0 when not enabled.
- Pop and push in the same cycle are both honoured. The issue rule guarantees no overflow.
- REDIRECT=1 at an edge:
  - FIFO cleared, INFLIGHT cleared; the in-flight response is discarded.
  - PC←REDIRECT_ADDR; no issue that cycle.
  - A handshake coinciding with REDIRECT counts as completed.
- Back-to-back REDIRECT: each restarts the sequence and the last one wins.
- INSTR_VALID = FIFO nonempty. INSTR_DATA/INSTR_ADDR must stay stable while INSTR_VALID=1 and INSTR_READY=0.

## Timing
- Reset values: ROM_ENABLE=0, ROM_ADDR=RESET_ADDR, INSTR_VALID=0, INSTR_DATA=0, INSTR_ADDR=0; FIFO empty; INFLIGHT=0.
- Cold start, counting cycles after RST_N deasserts:
  - cycle 0: RESET_HOLD
  - cycle 1: issue RESET_ADDR
  - cycle 2: data returns
  - cycle 3: INSTR_VALID=1
- Redirect latency: REDIRECT high in cycle c → issue in c+1 → INSTR_VALID with INSTR_ADDR=REDIRECT_ADDR in cycle c+3.
- Throughput is 1 word/cycle with INSTR_READY held high. With INSTR_READY low, the block stalls with FIFO full (2) and issues nothing.
- RST_N assertion mid-operation clears all state immediately, without waiting for CLK. Pending data is lost.

## Structure
- Shared package fetch_pkg holds:
  - FSM enum fetch_state_t {RESET_HOLD, RUN}
  - constant FETCH_FIFO_DEPTH=2
  - typedef fetch_entry_t {addr, data}
- Sub-module fetch_fifo: 2-entry synchronous FIFO with push, pop, clear, count, and head outputs, plus async active-low reset.
- Issue/credit logic, PC, INFLIGHT, and the FSM live in rom_fetch_unit.

## Test plan
- Bench ROM model: word i = 0xA0000000+i.
- Cold start, INSTR_READY=1: first INSTR_VALID in cycle 3 with addr 0, data 0xA0000000. Then addr 1, 2, 3… on consecutive cycles with no bubbles.
- Backpressure: INSTR_READY=0 from cycle 5 for 10 cycles:
  - FIFO fills to 2 and ROM_ENABLE stays 0.
  - Head stays stable.
  - After release, addresses continue with no gap or duplicate.
- Redirect to 0x100 in steady state, arriving while one word is in flight and one is buffered:
  - Neither pre-redirect word appears.
  - The next valid word is addr 0x100, data 0xA0000100, exactly 3 cycles later.
- Wrap-around: redirect to 0x3FE (ADDR_DEPTH=10) → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Simultaneous REDIRECT and pop, followed by a second REDIRECT the next cycle: only the second target is delivered.
- Async reset asserted mid-stream with CLK stopped: INSTR_VALID and ROM_ENABLE drop to 0 immediately. After release, the cold-start sequence repeats from RESET_ADDR.
